// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - taken-branch update FIFO feeding the BTB write port
// Coalesces repeat updates to the newest pending EIP; flush drops everything queued.
module btb_update_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wb_valid,
   input  logic             wb_taken,
   input  logic [31:0]      wb_EIP,
   input  logic [31:0]      wb_FIP_E,
   input  logic [31:0]      wb_FIP_O,
   input  logic [31:0]      wb_target,
   output logic             wb_ready,
   input  logic             btb_hold,
   output logic             btb_LD,
   output logic [31:0]      btb_EIP_WB,
   output logic [31:0]      btb_FIP_E_WB,
   output logic [31:0]      btb_FIP_O_WB,
   output logic [31:0]      btb_target_WB,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int AW = CNT_W - 1;

   logic [31:0]      eip_mem    [DEPTH];
   logic [31:0]      fip_e_mem  [DEPTH];
   logic [31:0]      fip_o_mem  [DEPTH];
   logic [31:0]      target_mem [DEPTH];

   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW-1:0]    last_idx;
   logic [CNT_W-1:0] count_q;

   logic             accept;
   logic             drain;
   logic             same_eip;
   logic             head_leaving;
   logic             coalesce;
   logic             push;

   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign wb_ready = !full;

   assign accept = wb_valid & wb_taken & wb_ready;
   assign drain  = btb_LD;
   assign btb_LD = !empty & !btb_hold & !flush;

   // Newest pending entry sits just behind the tail while the queue is non-empty.
   assign last_idx     = tail - AW'(1);
   assign same_eip     = (eip_mem[last_idx] == wb_EIP);
   // A lone entry leaving this cycle cannot absorb the update, so enqueue it fresh.
   assign head_leaving = drain & (count_q == CNT_W'(1));
   assign coalesce     = accept & !empty & same_eip & !head_leaving;
   assign push         = accept & !coalesce;

   always_comb begin
      btb_EIP_WB    = '0;
      btb_FIP_E_WB  = '0;
      btb_FIP_O_WB  = '0;
      btb_target_WB = '0;
      if (!empty) begin
         btb_EIP_WB    = eip_mem[head];
         btb_FIP_E_WB  = fip_e_mem[head];
         btb_FIP_O_WB  = fip_o_mem[head];
         btb_target_WB = target_mem[head];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            eip_mem[i]    <= '0;
            fip_e_mem[i]  <= '0;
            fip_o_mem[i]  <= '0;
            target_mem[i] <= '0;
         end
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            eip_mem[tail]    <= wb_EIP;
            fip_e_mem[tail]  <= wb_FIP_E;
            fip_o_mem[tail]  <= wb_FIP_O;
            target_mem[tail] <= wb_target;
            tail             <= tail + AW'(1);
         end
         if (coalesce) begin
            fip_e_mem[last_idx]  <= wb_FIP_E;
            fip_o_mem[last_idx]  <= wb_FIP_O;
            target_mem[last_idx] <= wb_target;
         end
         if (drain) begin
            head <= head + AW'(1);
         end
         case ({push, drain})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - table-driven checks for btb_update_queue
// Inputs driven after negedge, outputs sampled 1ns later, state advances at posedge.
module tb_btb_update_queue;

   logic        clk = 1'b0;
   logic        rst, flush, wb_valid, wb_taken, btb_hold;
   logic [31:0] wb_EIP, wb_FIP_E, wb_FIP_O, wb_target;
   logic        wb_ready, btb_LD, empty, full;
   logic [31:0] btb_EIP_WB, btb_FIP_E_WB, btb_FIP_O_WB, btb_target_WB;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   int stale  = 0;

   always #5 clk = ~clk;

   btb_update_queue #(.DEPTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wb_valid(wb_valid), .wb_taken(wb_taken), .wb_EIP(wb_EIP),
      .wb_FIP_E(wb_FIP_E), .wb_FIP_O(wb_FIP_O), .wb_target(wb_target),
      .wb_ready(wb_ready), .btb_hold(btb_hold), .btb_LD(btb_LD),
      .btb_EIP_WB(btb_EIP_WB), .btb_FIP_E_WB(btb_FIP_E_WB),
      .btb_FIP_O_WB(btb_FIP_O_WB), .btb_target_WB(btb_target_WB),
      .count(count), .empty(empty), .full(full)
   );

   typedef struct {
      logic        rst, flush, v, tk, hold;
      logic [31:0] eip, tgt;
      logic        chk;
      logic        e_ld;
      logic [31:0] e_eip, e_tgt;
      int          e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic f, logic v, logic tk, logic h,
                               logic [31:0] eip, logic [31:0] tgt, logic c,
                               logic eld, logic [31:0] eeip, logic [31:0] etgt, int ecnt);
      vec_t x;
      x.rst = r; x.flush = f; x.v = v; x.tk = tk; x.hold = h;
      x.eip = eip; x.tgt = tgt; x.chk = c;
      x.e_ld = eld; x.e_eip = eeip; x.e_tgt = etgt; x.e_cnt = ecnt;
      return x;
   endfunction

   task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   function automatic bit dropped_eip(logic [31:0] e);
      return (e == 32'h90) || (e == 32'hA0) || (e == 32'hB0) ||
             (e == 32'hC0) || (e == 32'hD0);
   endfunction

   task automatic drive(logic r, logic f, logic v, logic tk, logic h,
                        logic [31:0] eip, logic [31:0] tgt);
      rst = r; flush = f; wb_valid = v; wb_taken = tk; btb_hold = h;
      wb_EIP = eip; wb_target = tgt; wb_FIP_E = tgt; wb_FIP_O = tgt + 32'h10;
   endtask

   initial begin
      logic [31:0] e_fo;
      int          lat;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      //              rst f  v  tk hold eip           tgt           chk ld eip_wb        tgt_wb        cnt
      vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,    32'h0,    0, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // single update, one-cycle latency
      vecs.push_back(mk(0, 0, 1, 1, 0, 32'h1000, 32'h2040, 1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h1000, 32'h2040, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // fill under hold, fifth refused, ordered drain
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10,   32'h110,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h20,   32'h120,  1, 0, 32'h10,   32'h110,  1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h30,   32'h130,  1, 0, 32'h10,   32'h110,  2));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h40,   32'h140,  1, 0, 32'h10,   32'h110,  3));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h50,   32'h150,  1, 0, 32'h10,   32'h110,  4));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,    32'h0,    1, 0, 32'h10,   32'h110,  4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h10,   32'h110,  4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h20,   32'h120,  3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h30,   32'h130,  2));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h40,   32'h140,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // coalesce under hold
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h80,   32'h100,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h80,   32'h200,  1, 0, 32'h80,   32'h100,  1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,    32'h0,    1, 0, 32'h80,   32'h200,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h80,   32'h200,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // not-taken is consumed without effect
      vecs.push_back(mk(0, 0, 1, 0, 0, 32'h90,   32'h190,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // flush at count 3 with a taken update presented
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'hA0,   32'h1A0,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'hB0,   32'h1B0,  1, 0, 32'hA0,   32'h1A0,  1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'hC0,   32'h1C0,  1, 0, 32'hA0,   32'h1A0,  2));
      vecs.push_back(mk(0, 1, 1, 1, 0, 32'hD0,   32'h1D0,  1, 0, 32'hA0,   32'h1A0,  3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // same EIP as a lone head that drains this cycle: fresh enqueue
      vecs.push_back(mk(0, 0, 1, 1, 0, 32'h50,   32'h250,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 32'h50,   32'h300,  1, 1, 32'h50,   32'h250,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h50,   32'h300,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // coalesce into the tail entry while the head drains
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h60,   32'h160,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h70,   32'h170,  1, 0, 32'h60,   32'h160,  1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 32'h70,   32'h270,  1, 1, 32'h60,   32'h160,  2));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 1, 32'h70,   32'h270,  1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      // reset while full and draining
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h11,   32'h111,  1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h12,   32'h112,  1, 0, 32'h11,   32'h111,  1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h13,   32'h113,  1, 0, 32'h11,   32'h111,  2));
      vecs.push_back(mk(0, 0, 1, 1, 1, 32'h14,   32'h114,  1, 0, 32'h11,   32'h111,  3));
      vecs.push_back(mk(1, 0, 1, 1, 0, 32'h15,   32'h115,  1, 1, 32'h11,   32'h111,  4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,    32'h0,    1, 0, 32'h0,    32'h0,    0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].flush, vecs[i].v, vecs[i].tk, vecs[i].hold,
               vecs[i].eip, vecs[i].tgt);
         #1;
         if (vecs[i].chk) begin
            e_fo = (vecs[i].e_cnt == 0) ? 32'h0 : vecs[i].e_tgt + 32'h10;
            chk("btb_LD",        i, {31'b0, btb_LD},   {31'b0, vecs[i].e_ld});
            chk("btb_EIP_WB",    i, btb_EIP_WB,        vecs[i].e_eip);
            chk("btb_FIP_E_WB",  i, btb_FIP_E_WB,      vecs[i].e_tgt);
            chk("btb_FIP_O_WB",  i, btb_FIP_O_WB,      e_fo);
            chk("btb_target_WB", i, btb_target_WB,     vecs[i].e_tgt);
            chk("count",         i, {29'b0, count},    vecs[i].e_cnt);
            chk("empty",         i, {31'b0, empty},    {31'b0, vecs[i].e_cnt == 0});
            chk("full",          i, {31'b0, full},     {31'b0, vecs[i].e_cnt == 4});
            chk("wb_ready",      i, {31'b0, wb_ready}, {31'b0, vecs[i].e_cnt != 4});
            if (btb_LD && dropped_eip(btb_EIP_WB)) stale++;
         end
      end

      // bounded wait for the first write after a single accept
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h33, 32'h333);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = -1;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (btb_LD && lat < 0) begin
            lat = k;
            chk("latency_eip", 100, btb_EIP_WB, 32'h33);
         end
         @(negedge clk);
      end
      chk("latency_cycles", 100, lat, 0);
      chk("count_after_latency", 100, {29'b0, count}, 32'h0);
      chk("no_stale_write", 101, stale, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
